// File: rtl/rf_rtype_sequencer_if.sv
// Instruction-issue handshake plus register-file read/write port of the R-type sequencer.
// master: the sequencer (RF initiator); slave: issue logic and register file.
interface rf_rtype_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] Rs_Addr;
  logic [ADDR_W-1:0] Rt_Addr;
  logic [DATA_W-1:0] Rs_Data;
  logic [DATA_W-1:0] Rt_Data;
  logic [ADDR_W-1:0] Rd_Addr;
  logic [DATA_W-1:0] Rd_Data;
  logic              RegWrite;
  logic              done;
  logic              illegal;

  modport master (
    input  instr_valid, instr, Rs_Data, Rt_Data,
    output instr_ready, Rs_Addr, Rt_Addr, Rd_Addr, Rd_Data, RegWrite, done, illegal
  );

  modport slave (
    output instr_valid, instr, Rs_Data, Rt_Data,
    input  instr_ready, Rs_Addr, Rt_Addr, Rd_Addr, Rd_Data, RegWrite, done, illegal
  );
endinterface

// File: rtl/rf_rtype_sequencer.sv
// Four-state (IDLE/READ/EXEC/WB) MIPS R-type sequencer driving a register file; all outputs registered.
// Optional macro RF_ZERO_REG_PROTECT_EN suppresses the write-back to register 0.
module rf_rtype_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  rf_rtype_sequencer_if.master bus
);
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] F_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] F_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] F_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] F_SLTU = 6'h2B;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opcode_q, opcode_d;
  logic [FUNCT_W-1:0]  funct_q, funct_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;

  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0]   rt_addr_q, rt_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                regwrite_q, regwrite_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;

  logic [DATA_W-1:0]   result_c;
  logic                legal_c;
  logic                unused_shamt;

  assign unused_shamt = &{1'b0, bus.instr[10:6]};

  // ALU and legality decode over the captured operands
  always_comb begin
    result_c = '0;
    legal_c  = (opcode_q == '0);
    case (funct_q)
      F_ADD:   result_c = op_a_q + op_b_q;
      F_SUB:   result_c = op_a_q - op_b_q;
      F_AND:   result_c = op_a_q & op_b_q;
      F_OR:    result_c = op_a_q | op_b_q;
      F_XOR:   result_c = op_a_q ^ op_b_q;
      F_NOR:   result_c = ~(op_a_q | op_b_q);
      F_SLT:   result_c = DATA_W'($signed(op_a_q) < $signed(op_b_q));
      F_SLTU:  result_c = DATA_W'(op_a_q < op_b_q);
      default: legal_c  = 1'b0;
    endcase
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    rd_d       = rd_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    ready_d    = 1'b0;
    rs_addr_d  = '0;
    rt_addr_d  = '0;
    rd_addr_d  = '0;
    rd_data_d  = '0;
    regwrite_d = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid && ready_q) begin
          state_d   = READ;
          opcode_d  = bus.instr[31:26];
          funct_d   = bus.instr[5:0];
          rd_d      = ADDR_W'(bus.instr[15:11]);
          rs_addr_d = ADDR_W'(bus.instr[25:21]);
          rt_addr_d = ADDR_W'(bus.instr[20:16]);
        end else begin
          ready_d = 1'b1;
        end
      end
      READ: begin
        state_d = EXEC;
        op_a_d  = bus.Rs_Data;
        op_b_d  = bus.Rt_Data;
      end
      EXEC: begin
        state_d = WB;
        if (legal_c) begin
          done_d    = 1'b1;
          rd_addr_d = rd_q;
          rd_data_d = result_c;
`ifdef RF_ZERO_REG_PROTECT_EN
          regwrite_d = (rd_q != '0);
`else
          regwrite_d = 1'b1;
`endif
        end else begin
          illegal_d = 1'b1;
        end
      end
      WB: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      funct_q    <= '0;
      rd_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      ready_q    <= 1'b0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      regwrite_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      funct_q    <= funct_d;
      rd_q       <= rd_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      ready_q    <= ready_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      regwrite_q <= regwrite_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.Rs_Addr     = rs_addr_q;
  assign bus.Rt_Addr     = rt_addr_q;
  assign bus.Rd_Addr     = rd_addr_q;
  assign bus.Rd_Data     = rd_data_q;
  assign bus.RegWrite    = regwrite_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
endmodule
